// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: jump flush, execute hold and fetch-busy bubbles,
// with hold-timeout detection and saturating stall/jump statistics.
module pipe_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned HOLD_MAX     = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        ex_hold_i,
    input  logic        bus_busy_i,
    output logic        jump_en_o,
    output logic [31:0] jump_addr_o,
    output logic        flush_o,
    output logic        stall_pc_o,
    output logic        stall_if_id_o,
    output logic        stall_id_ex_o,
    output logic        bubble_if_id_o,
    output logic        hold_timeout_o,
    output logic [31:0] stall_cycles_o,
    output logic [31:0] jump_count_o,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [2:0]  FLUSH_INIT = 3'(FLUSH_CYCLES);
    localparam logic [15:0] HOLD_LAST  = 16'(HOLD_MAX - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [2:0]  r_flush_cnt;
    logic [2:0]  w_flush_cnt_next;
    logic [15:0] r_hold_cnt;
    logic [15:0] w_hold_base;
    logic        r_hold_timeout;
    logic [31:0] r_stall_cycles;
    logic [31:0] r_jump_count;
    logic        w_accept;
    logic        w_hold_stall;

    always_comb begin
        w_next_state     = r_state;
        w_flush_cnt_next = r_flush_cnt;
        w_accept         = 1'b0;
        w_hold_stall     = 1'b0;
        jump_en_o        = 1'b0;
        jump_addr_o      = '0;
        flush_o          = 1'b0;
        stall_pc_o       = 1'b0;
        stall_if_id_o    = 1'b0;
        stall_id_ex_o    = 1'b0;
        bubble_if_id_o   = 1'b0;
        if (rst_n) begin
            if (jump_en_i && (r_state != FLUSH)) begin
                w_accept         = 1'b1;
                jump_en_o        = 1'b1;
                jump_addr_o      = jump_addr_i;
                flush_o          = 1'b1;
                w_next_state     = FLUSH;
                w_flush_cnt_next = FLUSH_INIT;
            end else if (r_state == FLUSH) begin
                flush_o          = 1'b1;
                w_flush_cnt_next = r_flush_cnt - 3'd1;
                if (r_flush_cnt <= 3'd1) begin
                    w_next_state = RUN;
                end
            end else if (ex_hold_i) begin
                w_hold_stall  = 1'b1;
                stall_pc_o    = 1'b1;
                stall_if_id_o = 1'b1;
                stall_id_ex_o = 1'b1;
                w_next_state  = HOLD;
            end else begin
                w_next_state = RUN;
                if (bus_busy_i) begin
                    stall_pc_o     = 1'b1;
                    bubble_if_id_o = 1'b1;
                end
            end
        end
    end

    // The RUN->HOLD entry cycle counts as hold cycle one, so the count
    // restarts from zero whenever the previous cycle was not a hold.
    assign w_hold_base = (r_state == HOLD) ? r_hold_cnt : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= RUN;
            r_flush_cnt    <= '0;
            r_hold_cnt     <= '0;
            r_hold_timeout <= 1'b0;
            r_stall_cycles <= '0;
            r_jump_count   <= '0;
        end else begin
            r_state     <= w_next_state;
            r_flush_cnt <= w_flush_cnt_next;
            if (w_hold_stall) begin
                if (w_hold_base != '1) begin
                    r_hold_cnt <= w_hold_base + 16'd1;
                end else begin
                    r_hold_cnt <= w_hold_base;
                end
                if (w_hold_base == HOLD_LAST) begin
                    r_hold_timeout <= 1'b1;
                end
            end
            if (stall_pc_o && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_accept && (r_jump_count != '1)) begin
                r_jump_count <= r_jump_count + 32'd1;
            end
        end
    end

    assign hold_timeout_o = r_hold_timeout;
    assign stall_cycles_o = r_stall_cycles;
    assign jump_count_o   = r_jump_count;
    assign state_o        = r_state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus randomized traffic compared
// against a cycle-level behavioural model, on two parameterizations.
module tb_pipe_ctrl;

    localparam int unsigned A_FC = 1;
    localparam int unsigned A_HM = 4;
    localparam int unsigned B_FC = 3;
    localparam int unsigned B_HM = 255;

    typedef struct packed {
        logic        je;
        logic [31:0] ja;
        logic        fl;
        logic        spc;
        logic        sif;
        logic        sid;
        logic        bub;
        logic        to;
        logic [31:0] sc;
        logic [31:0] jc;
        logic [1:0]  st;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        jump_en_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        ex_hold_i = 1'b0;
    logic        bus_busy_i = 1'b0;

    logic        a_jump_en_o, a_flush_o, a_stall_pc_o, a_stall_if_id_o, a_stall_id_ex_o;
    logic        a_bubble_if_id_o, a_hold_timeout_o;
    logic [31:0] a_jump_addr_o, a_stall_cycles_o, a_jump_count_o;
    logic [1:0]  a_state_o;
    logic        b_jump_en_o, b_flush_o, b_stall_pc_o, b_stall_if_id_o, b_stall_id_ex_o;
    logic        b_bubble_if_id_o, b_hold_timeout_o;
    logic [31:0] b_jump_addr_o, b_stall_cycles_o, b_jump_count_o;
    logic [1:0]  b_state_o;

    int tests_run = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.FLUSH_CYCLES(A_FC), .HOLD_MAX(A_HM)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
        .ex_hold_i(ex_hold_i), .bus_busy_i(bus_busy_i),
        .jump_en_o(a_jump_en_o), .jump_addr_o(a_jump_addr_o), .flush_o(a_flush_o),
        .stall_pc_o(a_stall_pc_o), .stall_if_id_o(a_stall_if_id_o),
        .stall_id_ex_o(a_stall_id_ex_o), .bubble_if_id_o(a_bubble_if_id_o),
        .hold_timeout_o(a_hold_timeout_o), .stall_cycles_o(a_stall_cycles_o),
        .jump_count_o(a_jump_count_o), .state_o(a_state_o)
    );

    pipe_ctrl #(.FLUSH_CYCLES(B_FC), .HOLD_MAX(B_HM)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
        .ex_hold_i(ex_hold_i), .bus_busy_i(bus_busy_i),
        .jump_en_o(b_jump_en_o), .jump_addr_o(b_jump_addr_o), .flush_o(b_flush_o),
        .stall_pc_o(b_stall_pc_o), .stall_if_id_o(b_stall_if_id_o),
        .stall_id_ex_o(b_stall_id_ex_o), .bubble_if_id_o(b_bubble_if_id_o),
        .hold_timeout_o(b_hold_timeout_o), .stall_cycles_o(b_stall_cycles_o),
        .jump_count_o(b_jump_count_o), .state_o(b_state_o)
    );

    // Reference model: remaining flush cycles, whether the last cycle was a
    // hold stall, length of the current hold streak, and running totals.
    int unsigned m_frem[2];
    bit          m_holding[2];
    int unsigned m_streak[2];
    bit          m_to[2];
    logic [31:0] m_stall[2];
    logic [31:0] m_jump[2];

    function automatic int unsigned fc_of(input int k);
        return (k == 0) ? A_FC : B_FC;
    endfunction

    function automatic int unsigned hm_of(input int k);
        return (k == 0) ? A_HM : B_HM;
    endfunction

    function automatic obs_t model_out(input int k);
        obs_t e;
        e = '0;
        e.to = m_to[k];
        e.sc = m_stall[k];
        e.jc = m_jump[k];
        e.st = (m_frem[k] > 0) ? 2'd1 : (m_holding[k] ? 2'd2 : 2'd0);
        if (rst_n) begin
            if (jump_en_i && m_frem[k] == 0) begin
                e.je = 1'b1;
                e.ja = jump_addr_i;
                e.fl = 1'b1;
            end else if (m_frem[k] > 0) begin
                e.fl = 1'b1;
            end else if (ex_hold_i) begin
                e.spc = 1'b1;
                e.sif = 1'b1;
                e.sid = 1'b1;
            end else if (bus_busy_i) begin
                e.spc = 1'b1;
                e.bub = 1'b1;
            end
        end
        return e;
    endfunction

    function automatic obs_t got(input int k);
        obs_t g;
        if (k == 0)
            g = '{a_jump_en_o, a_jump_addr_o, a_flush_o, a_stall_pc_o, a_stall_if_id_o,
                  a_stall_id_ex_o, a_bubble_if_id_o, a_hold_timeout_o, a_stall_cycles_o,
                  a_jump_count_o, a_state_o};
        else
            g = '{b_jump_en_o, b_jump_addr_o, b_flush_o, b_stall_pc_o, b_stall_if_id_o,
                  b_stall_id_ex_o, b_bubble_if_id_o, b_hold_timeout_o, b_stall_cycles_o,
                  b_jump_count_o, b_state_o};
        return g;
    endfunction

    task automatic model_step(input int k);
        bit acc, hs, stalled;
        if (!rst_n) begin
            m_frem[k] = 0; m_holding[k] = 0; m_streak[k] = 0;
            m_to[k] = 0; m_stall[k] = '0; m_jump[k] = '0;
        end else begin
            acc     = jump_en_i && m_frem[k] == 0;
            hs      = !acc && m_frem[k] == 0 && ex_hold_i;
            stalled = !acc && m_frem[k] == 0 && (ex_hold_i || bus_busy_i);
            if (hs) begin
                m_streak[k] = m_holding[k] ? m_streak[k] + 1 : 1;
                if (m_streak[k] >= hm_of(k)) m_to[k] = 1;
            end
            if (stalled && m_stall[k] != 32'hFFFF_FFFF) m_stall[k] = m_stall[k] + 1;
            if (acc && m_jump[k] != 32'hFFFF_FFFF) m_jump[k] = m_jump[k] + 1;
            m_holding[k] = hs;
            if (acc) m_frem[k] = fc_of(k);
            else if (m_frem[k] > 0) m_frem[k] = m_frem[k] - 1;
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    task automatic drive(input bit rst, input bit je, input logic [31:0] ja,
                         input bit h, input bit b);
        @(negedge clk);
        rst_n = rst; jump_en_i = je; jump_addr_i = ja; ex_hold_i = h; bus_busy_i = b;
        #1;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic reset_dut();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
        tests_run++;
        if ({a_jump_en_o, a_flush_o, a_stall_pc_o, a_stall_if_id_o, a_stall_id_ex_o,
             a_bubble_if_id_o, a_jump_addr_o} !== '0) begin
            fails++;
            $display("FAIL reset_comb_a: got %b/%h expected all 0",
                     {a_jump_en_o, a_flush_o, a_stall_pc_o, a_bubble_if_id_o}, a_jump_addr_o);
        end
        drive(1'b0, 1'b1, 32'h1234_5678, 1'b1, 1'b0);
        tests_run++;
        if (got(0) !== obs_t'('0)) begin
            fails++; $display("FAIL reset_state_a: got %h expected %h", got(0), obs_t'('0));
        end
        tests_run++;
        if (got(1) !== obs_t'('0)) begin
            fails++; $display("FAIL reset_state_b: got %h expected %h", got(1), obs_t'('0));
        end
        idle();
        tests_run++;
        if (got(0) !== obs_t'('0)) begin
            fails++; $display("FAIL reset_idle_a: got %h expected %h", got(0), obs_t'('0));
        end
    endtask

    task automatic test_jump();
        reset_dut();
        drive(1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
        tests_run++;
        if (a_jump_en_o !== 1'b1 || a_jump_addr_o !== 32'h100 || a_flush_o !== 1'b1) begin
            fails++;
            $display("FAIL jump_accept: got en=%b addr=%h flush=%b expected en=1 addr=00000100 flush=1",
                     a_jump_en_o, a_jump_addr_o, a_flush_o);
        end
        idle();
        tests_run++;
        if (a_flush_o !== 1'b1 || a_state_o !== 2'd1 || a_jump_en_o !== 1'b0) begin
            fails++;
            $display("FAIL jump_flush_cycle: got flush=%b state=%0d en=%b expected 1/1/0",
                     a_flush_o, a_state_o, a_jump_en_o);
        end
        idle();
        tests_run++;
        if (a_state_o !== 2'd0 || a_flush_o !== 1'b0 || a_jump_count_o !== 32'd1) begin
            fails++;
            $display("FAIL jump_done: got state=%0d flush=%b count=%0d expected 0/0/1",
                     a_state_o, a_flush_o, a_jump_count_o);
        end
    endtask

    task automatic test_flush_len();
        int na, nb;
        reset_dut();
        na = 0; nb = 0;
        drive(1'b1, 1'b1, 32'h0000_0400, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            na += int'(a_flush_o);
            nb += int'(b_flush_o);
            idle();
        end
        tests_run++;
        if (na != A_FC + 1) begin
            fails++; $display("FAIL flush_len_a: got %0d expected %0d", na, A_FC + 1);
        end
        tests_run++;
        if (nb != B_FC + 1) begin
            fails++; $display("FAIL flush_len_b: got %0d expected %0d", nb, B_FC + 1);
        end
    endtask

    task automatic test_hold();
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
            tests_run++;
            if ({a_stall_pc_o, a_stall_if_id_o, a_stall_id_ex_o, a_bubble_if_id_o} !== 4'b1110 ||
                a_state_o !== ((i == 0) ? 2'd0 : 2'd2)) begin
                fails++;
                $display("FAIL hold_cycle%0d: got stalls=%b state=%0d expected 1110 state=%0d",
                         i, {a_stall_pc_o, a_stall_if_id_o, a_stall_id_ex_o, a_bubble_if_id_o},
                         a_state_o, (i == 0) ? 0 : 2);
            end
        end
        idle();
        tests_run++;
        if ({a_stall_pc_o, a_stall_if_id_o, a_stall_id_ex_o} !== 3'b000 ||
            a_state_o !== 2'd2 || a_stall_cycles_o !== 32'd3) begin
            fails++;
            $display("FAIL hold_release: got stalls=%b state=%0d cycles=%0d expected 000/2/3",
                     {a_stall_pc_o, a_stall_if_id_o, a_stall_id_ex_o}, a_state_o, a_stall_cycles_o);
        end
        idle();
        tests_run++;
        if (a_state_o !== 2'd0) begin
            fails++; $display("FAIL hold_back_to_run: got %0d expected 0", a_state_o);
        end
    endtask

    task automatic test_priority();
        reset_dut();
        drive(1'b1, 1'b1, 32'h0000_2000, 1'b1, 1'b1);
        tests_run++;
        if (a_jump_en_o !== 1'b1 ||
            {a_stall_pc_o, a_stall_if_id_o, a_stall_id_ex_o, a_bubble_if_id_o} !== 4'b0000) begin
            fails++;
            $display("FAIL prio_accept: got en=%b stalls=%b expected en=1 stalls=0000", a_jump_en_o,
                     {a_stall_pc_o, a_stall_if_id_o, a_stall_id_ex_o, a_bubble_if_id_o});
        end
        drive(1'b1, 1'b1, 32'h0000_3000, 1'b1, 1'b1);
        tests_run++;
        if (a_jump_en_o !== 1'b0 || a_flush_o !== 1'b1 ||
            {a_stall_pc_o, a_stall_if_id_o, a_stall_id_ex_o, a_bubble_if_id_o} !== 4'b0000) begin
            fails++;
            $display("FAIL prio_in_flush: got en=%b flush=%b stalls=%b expected 0/1/0000",
                     a_jump_en_o, a_flush_o,
                     {a_stall_pc_o, a_stall_if_id_o, a_stall_id_ex_o, a_bubble_if_id_o});
        end
        idle();
        tests_run++;
        if (a_jump_count_o !== 32'd1) begin
            fails++; $display("FAIL prio_count: got %0d expected 1", a_jump_count_o);
        end
    endtask

    task automatic test_timeout();
        reset_dut();
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
            tests_run++;
            if (a_hold_timeout_o !== ((i >= 5) ? 1'b1 : 1'b0)) begin
                fails++;
                $display("FAIL timeout_hold%0d: got %b expected %b", i, a_hold_timeout_o, i >= 5);
            end
        end
        for (int i = 0; i < 2; i++) begin
            idle();
            tests_run++;
            if (a_hold_timeout_o !== 1'b1 || a_state_o === 2'd1) begin
                fails++;
                $display("FAIL timeout_sticky%0d: got to=%b state=%0d expected to=1", i,
                         a_hold_timeout_o, a_state_o);
            end
        end
        tests_run++;
        if (b_hold_timeout_o !== 1'b0) begin
            fails++; $display("FAIL timeout_b_quiet: got %b expected 0", b_hold_timeout_o);
        end
    endtask

    task automatic test_busy();
        reset_dut();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
            tests_run++;
            if ({a_stall_pc_o, a_stall_if_id_o, a_stall_id_ex_o, a_bubble_if_id_o} !== 4'b1001) begin
                fails++;
                $display("FAIL busy_cycle%0d: got %b expected 1001", i,
                         {a_stall_pc_o, a_stall_if_id_o, a_stall_id_ex_o, a_bubble_if_id_o});
            end
        end
        idle();
        tests_run++;
        if ({a_stall_pc_o, a_bubble_if_id_o} !== 2'b00 || a_stall_cycles_o !== 32'd2 ||
            a_state_o !== 2'd0) begin
            fails++;
            $display("FAIL busy_release: got pc=%b bub=%b cycles=%0d state=%0d expected 0/0/2/0",
                     a_stall_pc_o, a_bubble_if_id_o, a_stall_cycles_o, a_state_o);
        end
    endtask

    task automatic test_reset_mid_flush();
        reset_dut();
        drive(1'b1, 1'b1, 32'h0000_0800, 1'b0, 1'b0);
        idle();
        tests_run++;
        if (b_state_o !== 2'd1 || b_flush_o !== 1'b1) begin
            fails++;
            $display("FAIL midflush_pre: got state=%0d flush=%b expected 1/1", b_state_o, b_flush_o);
        end
        reset_dut();
        idle();
        tests_run++;
        if (b_state_o !== 2'd0 || b_flush_o !== 1'b0 || b_stall_cycles_o !== '0 ||
            b_jump_count_o !== '0 || b_hold_timeout_o !== 1'b0) begin
            fails++;
            $display("FAIL midflush_post: got state=%0d flush=%b sc=%0d jc=%0d to=%b expected all 0",
                     b_state_o, b_flush_o, b_stall_cycles_o, b_jump_count_o, b_hold_timeout_o);
        end
    endtask

    task automatic test_random();
        bit h;
        h = 1'b0;
        reset_dut();
        for (int n = 0; n < 600; n++) begin
            h = h ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 3) == 0);
            drive($urandom_range(0, 63) != 0, $urandom_range(0, 5) == 0, $urandom, h,
                  $urandom_range(0, 2) == 0);
            for (int k = 0; k < 2; k++) begin
                tests_run++;
                if (got(k) !== model_out(k)) begin
                    fails++;
                    $display("FAIL random_dut%0d_cycle%0d: got %h expected %h", k, n, got(k),
                             model_out(k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_jump();
        test_flush_len();
        test_hold();
        test_priority();
        test_timeout();
        test_busy();
        test_reset_mid_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have parameter FLUSH_CYCLES, default 1, giving the number of extra flush cycles after a jump (legal 1..7).
REQ-002 The block SHALL have parameter HOLD_MAX, default 255, giving the hold-cycle count at which a timeout is flagged (legal 1..65535).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port jump_en_i, input, 1 bit: execute-stage taken jump/branch.
REQ-006 The block SHALL have port jump_addr_i, input, 32 bits: execute-stage jump target.
REQ-007 The block SHALL have port ex_hold_i, input, 1 bit: level; execute needs the current instruction held.
REQ-008 The block SHALL have port bus_busy_i, input, 1 bit: level; instruction fetch data is not valid this cycle.
REQ-009 The block SHALL have port jump_en_o, output, 1 bit: PC redirect strobe.
REQ-010 The block SHALL have port jump_addr_o, output, 32 bits: PC redirect target.
REQ-011 The block SHALL have port flush_o, output, 1 bit: load NOP (32'h00000013) into the if_id and id_ex registers.
REQ-012 The block SHALL have port stall_pc_o, stall_if_id_o and stall_id_ex_o, outputs, 1 bit each: hold the named register.
REQ-013 The block SHALL have port bubble_if_id_o, output, 1 bit: load NOP into if_id only.
REQ-014 The block SHALL have port hold_timeout_o, output, 1 bit: sticky hold-timeout flag.
REQ-015 The block SHALL have port stall_cycles_o, output, 32 bits: saturating count of cycles with stall_pc_o=1.
REQ-016 The block SHALL have port jump_count_o, output, 32 bits: saturating count of accepted jumps.
REQ-017 The block SHALL have port state_o, output, 2 bits: FSM state, encoded RUN=0, FLUSH=1, HOLD=2.

Function
REQ-018 FSM states SHALL be RUN, FLUSH and HOLD.
REQ-019 A jump SHALL be accepted when jump_en_i=1 and state is not FLUSH.
  - jump_en_i in FLUSH is ignored: the execute instruction is already a NOP.
REQ-020 In a jump-accept cycle, outputs SHALL be combinational (zero latency):
  - jump_en_o=1, jump_addr_o=jump_addr_i, flush_o=1, all stall outputs 0, bubble_if_id_o=0.
  - Next state is FLUSH; flush counter loads FLUSH_CYCLES.
REQ-021 Jump acceptance SHALL take priority over ex_hold_i and bus_busy_i in the same cycle; both are ignored in that cycle.
REQ-022 In FLUSH, the block SHALL drive flush_o=1, decrement the flush counter each cycle, and return to RUN in the cycle after the counter reads 1.
  - Total flush_o assertion is FLUSH_CYCLES+1 cycles per jump.
REQ-023 In FLUSH, stall outputs and bubble_if_id_o SHALL be 0 regardless of inputs.
REQ-024 With no jump accepted and ex_hold_i=1 in RUN or HOLD, the block SHALL drive:
  - stall_pc_o = stall_if_id_o = stall_id_ex_o = 1, bubble_if_id_o=0.
  - Next state is HOLD.
REQ-025 With no jump accepted, ex_hold_i=0 and bus_busy_i=1 in RUN or HOLD, the block SHALL drive stall_pc_o=1 and bubble_if_id_o=1, with stall_if_id_o = stall_id_ex_o = 0.
REQ-026 In HOLD, ex_hold_i=0 with no jump SHALL return the FSM to RUN next cycle.
REQ-027 A 16-bit hold counter SHALL count consecutive ex_hold_i cycles and track the timeout:
  - Clears on entry to HOLD from RUN, then increments each HOLD cycle with ex_hold_i=1.
  - Saturates at 65535.
  - When it equals HOLD_MAX-1 with ex_hold_i=1, hold_timeout_o is set the next cycle.
REQ-028 hold_timeout_o SHALL remain 1 until reset; a timeout SHALL NOT alter FSM or stall behaviour.
REQ-029 stall_cycles_o SHALL increment by 1 each cycle stall_pc_o=1, saturating at 32'hFFFFFFFF.
REQ-030 jump_count_o SHALL increment by 1 per accepted jump, saturating at 32'hFFFFFFFF.
REQ-031 With none of the above conditions active, all control outputs SHALL be 0 and jump_addr_o SHALL be 32'h0.

Reset
REQ-032 While rst_n=0 at a rising edge, the block SHALL clear the following on that edge:
  - State to RUN; flush and hold counters to 0.
  - hold_timeout_o, stall_cycles_o and jump_count_o to 0.
REQ-033 While rst_n=0, all combinational control outputs SHALL be forced to 0 and jump_addr_o to 32'h0, regardless of inputs.
REQ-034 Reset asserted mid-FLUSH or mid-HOLD SHALL abandon the operation; after release the block starts in RUN with no residual flush.

Verification
REQ-035 Scenario: jump_en_i=1 with jump_addr_i=32'h0000_0100 in RUN, FLUSH_CYCLES=1 -> same cycle jump_en_o=1, jump_addr_o=32'h100, flush_o=1; next cycle flush_o=1 and state_o=1; then state_o=0; jump_count_o=1.
REQ-036 Scenario: ex_hold_i high for 3 cycles -> stall_pc_o, stall_if_id_o and stall_id_ex_o high exactly 3 cycles; stall_cycles_o=3; state_o=2 for 3 cycles, then 0.
REQ-037 Scenario: jump_en_i, ex_hold_i and bus_busy_i all 1 in RUN -> jump accepted, stalls 0, bubble_if_id_o=0; a second jump_en_i in the following FLUSH cycle is ignored and jump_count_o stays 1.
REQ-038 Scenario: HOLD_MAX=4, ex_hold_i held for 6 cycles -> hold_timeout_o rises after the 4th hold cycle and stays 1 after ex_hold_i drops.
REQ-039 Scenario: bus_busy_i=1 for 2 cycles -> stall_pc_o=1 and bubble_if_id_o=1 for 2 cycles with stall_id_ex_o=0.
REQ-040 Scenario: rst_n=0 for 1 cycle mid-FLUSH, with FLUSH_CYCLES=3 -> next cycle state_o=0, flush_o=0, and all counters read 0.
